// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - Default address width and highest valid program address
package pc_sequencer_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_LAST_ADDR  = 255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between a controller and the pc sequencer.
//   master : controller side; drives enable/start/step/stop and the
//            decoded-instruction hints (halt_instr, jump_en, jump_addr),
//            observes pc/fetch/running/halted.
//   slave  : sequencer side; the mirror image.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  enable;
  logic                  start;
  logic                  step;
  logic                  stop;
  logic                  halt_instr;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  fetch;
  logic                  running;
  logic                  halted;

  modport master (
    output enable, start, step, stop, halt_instr, jump_en, jump_addr,
    input  pc, fetch, running, halted
  );

  modport slave (
    input  enable, start, step, stop, halt_instr, jump_en, jump_addr,
    output pc, fetch, running, halted
  );

endinterface

// File: rtl/pc_sequencer_next_logic.sv
// Combinational next-pc computation for an advance.
//   pc        : current program counter
//   jump_en   : take jump_addr instead of incrementing
//   jump_addr : jump target; anything above LAST_ADDR is clamped to 0
//   next_pc   : resulting program counter
module pc_next_logic
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LAST_ADDR  = DEF_LAST_ADDR
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ZERO = {ADDR_WIDTH{1'b0}};

  // Jump with clamp, otherwise increment with wrap at LAST_ADDR.
  // ">=" on the wrap keeps a stray out-of-range pc from counting past LAST.
  always_comb begin
    next_pc = ZERO;
    if (jump_en) begin
      if (jump_addr > LAST) begin
        next_pc = ZERO;
      end else begin
        next_pc = jump_addr;
      end
    end else begin
      if (pc >= LAST) begin
        next_pc = ZERO;
      end else begin
        next_pc = pc + ONE;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE / RUN / STEP / HALTED control of a pc
// advanced on prescaler enable ticks.
//   fast_clock : sole clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : slave side of pc_sequencer_if (commands in, pc/status out)
// All outputs are registered; fetch pulses for one cycle whenever pc is
// loaded by an advance or by a restart from HALTED.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LAST_ADDR  = DEF_LAST_ADDR
) (
  input  logic           fast_clock,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] ZERO = {ADDR_WIDTH{1'b0}};

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  fetch_r;
  logic                  running_r;
  logic                  halted_r;

  logic [1:0]            state_nx_s;
  logic [ADDR_WIDTH-1:0] pc_nx_s;
  logic                  fetch_nx_s;
  logic [ADDR_WIDTH-1:0] adv_pc_s;

  pc_next_logic #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LAST_ADDR  (LAST_ADDR)
  ) u_next (
    .pc        (pc_r),
    .jump_en   (bus.jump_en),
    .jump_addr (bus.jump_addr),
    .next_pc   (adv_pc_s)
  );

  // Next-state, next-pc and fetch decision.
  // In RUN/STEP, stop is checked before enable so it wins a coincident tick,
  // and halt_instr is checked before the advance so a HALT never moves pc.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    fetch_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx_s = ST_RUN;
        end else if (bus.step) begin
          state_nx_s = ST_STEP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (bus.stop) begin
          state_nx_s = ST_IDLE;
        end else if (bus.enable) begin
          if (bus.halt_instr) begin
            state_nx_s = ST_HALTED;
          end else begin
            pc_nx_s    = adv_pc_s;
            fetch_nx_s = 1'b1;
            state_nx_s = (state_r == ST_RUN) ? ST_RUN : ST_IDLE;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_HALTED: begin
        if (bus.start) begin
          pc_nx_s    = ZERO;
          fetch_nx_s = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_HALTED;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, pc and status registers; status flags decode the next state so
  // they line up with the state they describe.
  always_ff @(posedge fast_clock) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pc_r      <= ZERO;
      fetch_r   <= 1'b0;
      running_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      pc_r      <= pc_nx_s;
      fetch_r   <= fetch_nx_s;
      running_r <= (state_nx_s == ST_RUN);
      halted_r  <= (state_nx_s == ST_HALTED);
    end
  end

  assign bus.pc      = pc_r;
  assign bus.fetch   = fetch_r;
  assign bus.running = running_r;
  assign bus.halted  = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_WIDTH=4, LAST_ADDR=9).
// A mode-flag reference model is compared every cycle; directed scenarios
// add hand-computed literal expectations.
module tb_pc_sequencer;

  localparam int AW   = 4;
  localparam int LAST = 9;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc_no;

  // reference model: mode flags and pc as plain integers
  bit m_run;
  bit m_halt;
  bit m_wait;
  bit m_fetch;
  int m_pc;

  pc_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  pc_sequencer #(
    .ADDR_WIDTH (AW),
    .LAST_ADDR  (LAST)
  ) dut (
    .fast_clock (clk),
    .rst        (rst),
    .bus        (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_no, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_update();
    int ja;
    m_fetch = 1'b0;
    if (rst) begin
      m_pc = 0; m_run = 1'b0; m_halt = 1'b0; m_wait = 1'b0;
    end else if (m_halt) begin
      if (bus.start) begin
        m_pc = 0; m_halt = 1'b0; m_run = 1'b1; m_fetch = 1'b1;
      end
    end else if (m_run || m_wait) begin
      if (bus.stop) begin
        m_run = 1'b0; m_wait = 1'b0;
      end else if (bus.enable) begin
        if (bus.halt_instr) begin
          m_halt = 1'b1; m_run = 1'b0; m_wait = 1'b0;
        end else begin
          ja = int'(bus.jump_addr);
          if (bus.jump_en) m_pc = (ja <= LAST) ? ja : 0;
          else             m_pc = (m_pc + 1) % (LAST + 1);
          m_fetch = 1'b1;
          m_wait  = 1'b0;
        end
      end
    end else begin
      if (bus.start)     m_run  = 1'b1;
      else if (bus.step) m_wait = 1'b1;
    end
  endtask

  task automatic compare_model();
    check("model_pc",      int'(bus.pc),      m_pc);
    check("model_fetch",   int'(bus.fetch),   int'(m_fetch));
    check("model_running", int'(bus.running), int'(m_run));
    check("model_halted",  int'(bus.halted),  int'(m_halt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    cyc_no++;
    compare_model();
  endtask

  task automatic cyc(input bit en, input bit st, input bit sp, input bit so,
                     input bit hi, input bit je, input int ja, input bit r);
    bus.enable = en; bus.start = st; bus.step = sp; bus.stop = so;
    bus.halt_instr = hi; bus.jump_en = je; bus.jump_addr = AW'(ja); rst = r;
    tick();
    bus.enable = 1'b0; bus.start = 1'b0; bus.step = 1'b0; bus.stop = 1'b0;
    bus.halt_instr = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = 4'd0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // three quiet cycles followed by the enable tick (enable every 4th cycle)
  task automatic en4(input bit hi, input bit je, input int ja);
    idle(3);
    cyc(1, 0, 0, 0, hi, je, ja, 0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc_no = 0;
    m_pc = 0; m_run = 0; m_halt = 0; m_wait = 0; m_fetch = 0;
    rst = 1'b1;
    bus.enable = 1'b0; bus.start = 1'b0; bus.step = 1'b0; bus.stop = 1'b0;
    bus.halt_instr = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = 4'd0;
    @(negedge clk);

    // reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_pc", int'(bus.pc), 0);
    check("rst_fetch", int'(bus.fetch), 0);
    check("rst_running", int'(bus.running), 0);
    check("rst_halted", int'(bus.halted), 0);

    // start then three advances
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check("start_running", int'(bus.running), 1);
    check("start_pc_held", int'(bus.pc), 0);
    for (int i = 1; i <= 3; i++) begin
      en4(0, 0, 0);
      check("adv_pc", int'(bus.pc), i);
      check("adv_fetch", int'(bus.fetch), 1);
    end
    idle(1);
    check("fetch_one_cycle", int'(bus.fetch), 0);
    check("run_running", int'(bus.running), 1);

    // wrap at LAST_ADDR
    en4(0, 1, 9);
    check("jump9_pc", int'(bus.pc), 9);
    en4(0, 0, 0);
    check("wrap_pc", int'(bus.pc), 0);
    check("wrap_fetch", int'(bus.fetch), 1);

    // jump and out-of-range jump clamp
    en4(0, 1, 6);
    check("jump6_pc", int'(bus.pc), 6);
    en4(0, 1, 12);
    check("jump12_pc", int'(bus.pc), 0);

    // single step from IDLE at pc=4
    en4(0, 1, 4);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    check("stop_pc", int'(bus.pc), 4);
    check("stop_running", int'(bus.running), 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    en4(0, 0, 0);
    check("step_pc", int'(bus.pc), 5);
    check("step_fetch", int'(bus.fetch), 1);
    en4(0, 0, 0);
    check("step2_pc", int'(bus.pc), 5);
    check("step2_fetch", int'(bus.fetch), 0);
    check("step2_running", int'(bus.running), 0);

    // stop overrides coincident enable
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    check("stopen_pc", int'(bus.pc), 5);
    check("stopen_fetch", int'(bus.fetch), 0);
    check("stopen_running", int'(bus.running), 0);

    // halt, ignored commands, restart from 0
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    en4(1, 0, 0);
    check("halt_halted", int'(bus.halted), 1);
    check("halt_pc", int'(bus.pc), 5);
    check("halt_fetch", int'(bus.fetch), 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("halt_hold", int'(bus.halted), 1);
    check("halt_hold_pc", int'(bus.pc), 5);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check("restart_pc", int'(bus.pc), 0);
    check("restart_fetch", int'(bus.fetch), 1);
    check("restart_running", int'(bus.running), 1);
    check("restart_halted", int'(bus.halted), 0);

    // reset mid-run
    en4(0, 1, 7);
    check("pre_rst_pc", int'(bus.pc), 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("midrst_pc", int'(bus.pc), 0);
    check("midrst_running", int'(bus.running), 0);
    idle(1);
    check("postrst_fetch", int'(bus.fetch), 0);
    check("postrst_running", int'(bus.running), 0);

    // start beats step; reset aborts a pending step
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    check("start_wins", int'(bus.running), 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    en4(0, 0, 0);
    check("step_abort_pc", int'(bus.pc), 0);
    check("step_abort_fetch", int'(bus.fetch), 0);

    // randomized traffic, enable mostly every 4th cycle
    for (int c = 0; c < 4000; c++) begin
      cyc(((c % 4) == 3) || ($urandom_range(0, 15) == 0),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) == 0,
          int'($urandom_range(0, 15)),
          $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of program counter and jump address.
REQ-002 Parameter LAST_ADDR, default 8'd255, highest valid program address; must be < 2^ADDR_WIDTH.
REQ-003 fast_clock  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  one-cycle tick from the upstream prescaler; sets execution rate.
REQ-006 start  input  1  single-cycle request to begin continuous execution.
REQ-007 step  input  1  single-cycle request to execute exactly one instruction.
REQ-008 stop  input  1  single-cycle request to pause execution.
REQ-009 halt_instr  input  1  current instruction decodes as HALT.
REQ-010 jump_en  input  1  current instruction is a taken jump.
REQ-011 jump_addr  input  ADDR_WIDTH  jump target.
REQ-012 pc  output  ADDR_WIDTH  registered program counter.
REQ-013 fetch  output  1  registered; high for one cycle when pc holds a newly loaded value.
REQ-014 running  output  1  registered; high while in RUN.
REQ-015 halted  output  1  registered; high while in HALTED.

Function
REQ-016 FSM states, 2-bit: IDLE=0, RUN=1, STEP=2, HALTED=3.
REQ-017 IDLE: start -> RUN; else step -> STEP; pc held; enable ignored.
REQ-018 RUN: on enable, perform an advance (REQ-021); stays RUN unless halt_instr or stop.
REQ-019 STEP: waits for next enable; performs one advance, then IDLE (or HALTED if halt_instr).
REQ-020 HALTED: pc held; start -> pc=0, RUN, fetch=1; step, stop, enable ignored.
REQ-021 Advance priority: halt_instr (pc unchanged, -> HALTED, no fetch) > jump_en (pc=jump_addr) > increment.
REQ-022 Increment: pc==LAST_ADDR -> 0, else pc+1; no overflow beyond LAST_ADDR.
REQ-023 jump_addr > LAST_ADDR loads 0.
REQ-024 stop in RUN or STEP -> IDLE same edge, overrides a coincident enable; pc retained.
REQ-025 fetch asserts on the same edge pc takes its new value, for exactly one cycle; never for pc unchanged.
REQ-026 Advance latency: pc updates on the rising edge where enable=1 is sampled; zero extra cycles.
REQ-027 start/step while already in RUN/STEP ignored; simultaneous start and step in IDLE: start wins.

Reset
REQ-028 rst=1 at a rising edge: state=IDLE, pc=0, fetch=0, running=0, halted=0, regardless of other inputs.
REQ-029 rst mid-operation aborts any pending STEP; no fetch issued on the reset edge or the following cycle unless an advance occurs.

Structure
REQ-030 Shared package holds state encoding constants and default ADDR_WIDTH/LAST_ADDR.
REQ-031 One combinational sub-module pc_next_logic computes next pc (jump, increment, wrap, clamp); FSM and registers in pc_sequencer.

Verification (ADDR_WIDTH=4, LAST_ADDR=9, enable every 4th cycle)
REQ-032 Reset then start, 3 enables -> pc 1,2,3, one fetch pulse each, running=1.
REQ-033 RUN at pc=9, enable -> pc=0, fetch=1 (wrap).
REQ-034 RUN, jump_en=1 jump_addr=6 on enable -> pc=6; jump_addr=12 -> pc=0.
REQ-035 IDLE at pc=4, step then 2 enables -> pc=5 after first, unchanged after second, state IDLE.
REQ-036 RUN, stop and enable same cycle -> pc unchanged, IDLE, no fetch; halt_instr on enable -> halted=1, later start -> pc=0, RUN.
REQ-037 RUN at pc=7, rst=1 one cycle -> pc=0, IDLE, all outputs 0 next cycle.
